aes_128_ctr_keystream: RTL and testbench

//  AES-128 counter-mode keystream generator: 64-bit block counter plus fully pipelined AES-128 encrypt core.

---
 rtl/aes_128_ctr_keystream.sv | 252 +++++++++++++++++++++++++
 tb/tb_aes_128_ctr_keystream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_ctr_keystream.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_ctr_keystream
// Purpose  : AES-128 counter-mode keystream generator. A 64-bit block counter
//            forms the low half of the AES input block ({iv, count}). A fully
//            pipelined AES-128 encrypt core accepts one block per cycle and
//            produces AES_key({iv, count}) LATENCY cycles later. The AFU XORs
//            the keystream with plaintext lines to form ciphertext.
//
// Ports    : clk        - single clock, all state updates on posedge
//            reset      - synchronous, active-high; clears counter and pipe
//            on         - counter increment enable
//            load       - load counter with load_value (wins over on)
//            load_value - 64-bit counter preset
//            iv         - 64-bit nonce, upper half of the AES input block
//            key        - AES-128 key, FIPS-197 byte order (bit 127 = byte 0)
//            count      - current counter value (low half of AES input)
//            keystream  - AES_key({iv, count}) delayed LATENCY cycles
//            ks_valid   - keystream holds a block produced while on=1
//
// Config   : AES_CTR_VALID_EN defined   -> a LATENCY-deep shift register
//                                          carries 'on' beside the data and
//                                          drives ks_valid.
//            AES_CTR_VALID_EN undefined -> ks_valid is tied to 1.
//
// Revision : 1.0 - initial release
// ============================================================================
module aes_128_ctr_keystream (
  input  logic         clk,
  input  logic         reset,
  input  logic         on,
  input  logic         load,
  input  logic [63:0]  load_value,
  input  logic [63:0]  iv,
  input  logic [127:0] key,
  output logic [63:0]  count,
  output logic [127:0] keystream,
  output logic         ks_valid
);

  // One stage for the initial AddRoundKey plus two stages per round.
  localparam int LATENCY    = 21;
  localparam int NUM_ROUNDS = (LATENCY - 1) / 2;

  // --------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128). The
  // exponentiation maps 0 to 0, which is exactly the S-box convention.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      acc = gf_mul(acc, sq);
      sq  = gf_mul(sq, sq);
    end
    return acc;
  endfunction

  // S-box: inverse followed by the affine map
  // b' = b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4) ^ 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // --------------------------------------------------------------------------
  // Round transforms. Byte n of a block is bits [127-8n -: 8]; the state is
  // column-major, so byte n sits at row n%4, column n/4.
  // --------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r, (c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int rnd);
    logic [7:0] rc;
    case (rnd)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One step of the AES-128 key schedule: derive round key i from i-1.
  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                  input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // --------------------------------------------------------------------------
  // Block counter
  // --------------------------------------------------------------------------
  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (on) begin
      r_count <= r_count + 64'd1;   // natural wrap from all-ones to zero
    end
  end

  assign count = r_count;

  // --------------------------------------------------------------------------
  // AES pipeline
  //   r_state[0]   : {iv, count} ^ key             (stage 0)
  //   r_sub[i]     : SubBytes of r_state[i-1]      (round i, stage A)
  //   r_nkey[i]    : round key i                   (round i, stage A)
  //   r_state[i]   : ShiftRows/MixColumns/ARK      (round i, stage B)
  //   r_rkey[i]    : round key that went into r_state[i]; it travels with the
  //                  data so every block is expanded from the key it entered
  //                  with. The final round key has no consumer, so r_rkey
  //                  stops one entry short.
  // --------------------------------------------------------------------------
  logic [127:0] r_state [0:NUM_ROUNDS];
  logic [127:0] r_rkey  [0:NUM_ROUNDS-1];
  logic [127:0] r_sub   [1:NUM_ROUNDS];
  logic [127:0] r_nkey  [1:NUM_ROUNDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        r_state[i] <= '0;
      end
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        r_rkey[i] <= '0;
      end
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        r_sub[i]  <= '0;
        r_nkey[i] <= '0;
      end
    end else begin
      // The counter register is sampled every cycle regardless of 'on'.
      r_state[0] <= {iv, r_count} ^ key;
      r_rkey[0]  <= key;

      for (int rnd = 1; rnd <= NUM_ROUNDS; rnd++) begin
        // Stage A
        r_sub[rnd]  <= sub_bytes(r_state[rnd-1]);
        r_nkey[rnd] <= next_round_key(r_rkey[rnd-1], rcon(rnd));

        // Stage B: the last round omits MixColumns
        if (rnd == NUM_ROUNDS) begin
          r_state[rnd] <= shift_rows(r_sub[rnd]) ^ r_nkey[rnd];
        end else begin
          r_state[rnd] <= mix_columns(shift_rows(r_sub[rnd])) ^ r_nkey[rnd];
          r_rkey[rnd]  <= r_nkey[rnd];
        end
      end
    end
  end

  assign keystream = r_state[NUM_ROUNDS];

  // --------------------------------------------------------------------------
  // Optional valid tracking
  // --------------------------------------------------------------------------
`ifdef AES_CTR_VALID_EN
  logic [LATENCY-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[LATENCY-2:0], on};
    end
  end

  assign ks_valid = r_valid[LATENCY-1];
`else
  assign ks_valid = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_128_ctr_keystream.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_ctr_keystream
// Purpose  : Self-checking bench for aes_128_ctr_keystream. Known-answer
//            vectors from a table, hand-written wrap/priority/reset
//            sequences and randomized traffic, all compared against a
//            byte-array AES-128 reference model with a table S-box.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_128_ctr_keystream;

  logic         clk = 1'b0;
  logic         reset;
  logic         on;
  logic         load;
  logic [63:0]  load_value;
  logic [63:0]  iv;
  logic [127:0] key;
  logic [63:0]  count;
  logic [127:0] keystream;
  logic         ks_valid;

  always #5 clk = ~clk;

  aes_128_ctr_keystream dut (
    .clk        (clk),
    .reset      (reset),
    .on         (on),
    .load       (load),
    .load_value (load_value),
    .iv         (iv),
    .key        (key),
    .count      (count),
    .keystream  (keystream),
    .ks_valid   (ks_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // --------------------------------------------------------------------------
  // Reference model: FIPS-197 S-box table, textbook key expansion and rounds
  // --------------------------------------------------------------------------
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = sbox_rows[x[7:4]];
    return row[127-8*x[3:0] -: 8];
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return b[7] ? (({b[6:0], 1'b0}) ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]) ^ rc, sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])};
        rc  = mul2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sb(s[r+4*((c+r)%4)]);
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul2(t[4*c]) ^ mul2(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul2(t[4*c+1]) ^ mul2(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul2(t[4*c+2]) ^ mul2(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = mul2(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ mul2(t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    ct = '0;
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // --------------------------------------------------------------------------
  // Cycle-level scoreboard. Expected blocks / on-bits are queued in the cycle
  // their counter value is visible and compared 21 cycles later.
  // --------------------------------------------------------------------------
  logic [63:0]  m_count = '0;
  logic [127:0] exp_q [$];
  bit           known_q [$];
  bit           valid_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Key changes invalidate every block still in flight.
  task automatic set_key(input logic [127:0] k);
    key = k;
    foreach (known_q[i]) known_q[i] = 1'b0;
  endtask

  task automatic tick(input bit r, input bit o, input bit l, input logic [63:0] lv);
    logic [127:0] exp_ks;
    bit           exp_known;
    bit           exp_v;
    reset = r; on = o; load = l; load_value = lv;
    if (r) begin
      exp_q.delete(); known_q.delete(); valid_q.delete();
      m_count = '0;
    end else begin
      exp_q.push_back(aes_ref(key, {iv, m_count}));
      known_q.push_back(1'b1);
      valid_q.push_back(o);
      if (l)      m_count = lv;
      else if (o) m_count = m_count + 64'd1;
    end
    @(posedge clk); #1;
    check("count", {64'd0, count}, {64'd0, m_count});
    if (r) begin
      check("ks_in_reset", keystream, '0);
    end else if (exp_q.size() == 21) begin
      exp_ks    = exp_q.pop_front();
      exp_known = known_q.pop_front();
      if (exp_known) check("keystream", keystream, exp_ks);
    end
    exp_v = 1'b0;
    if (valid_q.size() == 21) exp_v = valid_q.pop_front();
`ifndef AES_CTR_VALID_EN
    exp_v = 1'b1;
`endif
    check("ks_valid", {127'd0, ks_valid}, {127'd0, exp_v});
  endtask

  // --------------------------------------------------------------------------
  // Known-answer table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [127:0] k;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic [127:0] exp;
  } kat_t;

  kat_t kats [4];

  initial begin
    kats[0] = '{128'h0, 64'h0, 64'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    kats[1] = '{128'h000102030405060708090a0b0c0d0e0f, 64'h0011223344556677,
                64'h8899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    kats[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 64'h3243f6a8885a308d,
                64'h313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    kats[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 64'hf0f1f2f3f4f5f6f7,
                64'hf8f9fafbfcfdfeff, 128'hec8cdf7398607cb0f2d21675ea9ea1e4};

    reset = 1'b1; on = 1'b0; load = 1'b0; load_value = '0; iv = '0; key = '0;

    // Reset, then the zero vector exactly as the block comes out of reset
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    repeat (22) tick(0, 0, 0, 0);
    check("zero_vector", keystream, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

    // Table-driven known answers: load the counter, hold, compare
    for (int v = 0; v < 4; v++) begin
      set_key(kats[v].k);
      iv = kats[v].nonce;
      tick(0, 0, 1, kats[v].ctr);
      repeat (21) tick(0, 0, 0, 0);
      check($sformatf("kat%0d", v), keystream, kats[v].exp);
    end

    // Wrap and load priority
    tick(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("load_all_ones", {64'd0, count}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    tick(0, 1, 0, 0);
    check("wrap_to_zero", {64'd0, count}, 128'd0);
    tick(0, 1, 1, 64'd5);
    check("load_beats_on", {64'd0, count}, 128'd5);

    // Streaming from zero, one block per cycle
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    iv = 64'hf0f1f2f3f4f5f6f7;
    tick(1, 0, 0, 0);
    repeat (100) tick(0, 1, 0, 0);
    check("stream_count", {64'd0, count}, 128'd100);

    // Mid-run reset at cycle 10 of streaming
    tick(1, 0, 0, 0);
    repeat (10) tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    check("midreset_count", {64'd0, count}, 128'd0);
    check("midreset_ks", keystream, 128'd0);
    repeat (30) tick(0, 1, 0, 0);

    // Randomized traffic
    set_key({$urandom, $urandom, $urandom, $urandom});
    iv = {$urandom, $urandom};
    for (int i = 0; i < 300; i++) begin
      bit r, o, l;
      logic [63:0] lv;
      if (i == 150) set_key({$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 9) == 0) iv = {$urandom, $urandom};
      r  = ($urandom_range(0, 99) == 0);
      o  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                       : 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      tick(r, o, l, lv);
    end
    repeat (22) tick(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
